// File: rtl/sipo_pkg.sv
// Shared constants and sizing helper for the serial-in parallel-out converter.
package sipo_pkg;

    localparam int SIPO_DEF_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Free-running bit counter for sipo_special; last_bit marks the final bit of a frame.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
) (
    input  logic clock,
    input  logic reset,
    output logic last_bit
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0] bit_cnt;

    // Explicit wrap keeps non-power-of-two widths in range 0..WIDTH-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         bit_cnt <= '0;
        else if (last_bit) bit_cnt <= '0;
        else               bit_cnt <= bit_cnt + CW'(1);
    end

    assign last_bit = (bit_cnt == LAST);

endmodule

// File: rtl/sipo_special.sv
// Serial-in parallel-out converter that publishes a word once per WIDTH-bit frame.
// Optional one-cycle frame_done strobe is enabled with macro SIPO_FRAME_STROBE_EN.
module sipo_special
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_in,
    output logic [WIDTH-1:0] d_out
`ifdef SIPO_FRAME_STROBE_EN
    ,
    output logic             frame_done
`endif
);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             last_bit;

    sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .last_bit (last_bit)
    );

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_next = {shift_reg[WIDTH-2:0], d_in};
        end else begin : g_lsb
            assign shift_next = {d_in, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    // d_out takes shift_next so the frame's final bit is included on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            d_out     <= '0;
        end else begin
            shift_reg <= shift_next;
            if (last_bit) d_out <= shift_next;
        end
    end

`ifdef SIPO_FRAME_STROBE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= last_bit;
    end
`endif

endmodule

// File: tb/tb_sipo_special.sv
// Self-checking bench: MSB-first and LSB-first instances against a frame-level model.
module tb_sipo_special;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       d_in  = 1'b0;
    logic [7:0] d_out_m;
    logic [7:0] d_out_l;
`ifdef SIPO_FRAME_STROBE_EN
    logic       fd_m;
    logic       fd_l;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // model state: bits since last reset, last 8 kept, and expected outputs
    bit         win[$];
    int         nbits = 0;
    logic [7:0] exp_m = 8'h00;
    logic [7:0] exp_l = 8'h00;
    logic       exp_fd = 1'b0;

    always #5 clock = ~clock;

    sipo_special #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock (clock), .reset (reset), .d_in (d_in), .d_out (d_out_m)
`ifdef SIPO_FRAME_STROBE_EN
        , .frame_done (fd_m)
`endif
    );

    sipo_special #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock (clock), .reset (reset), .d_in (d_in), .d_out (d_out_l)
`ifdef SIPO_FRAME_STROBE_EN
        , .frame_done (fd_l)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_msb"}, d_out_m, exp_m);
        chk({tag, "_lsb"}, d_out_l, exp_l);
`ifdef SIPO_FRAME_STROBE_EN
        chk({tag, "_fd_msb"}, {7'd0, fd_m}, {7'd0, exp_fd});
        chk({tag, "_fd_lsb"}, {7'd0, fd_l}, {7'd0, exp_fd});
`endif
    endtask

    task automatic model_reset();
        win.delete();
        nbits  = 0;
        exp_m  = 8'h00;
        exp_l  = 8'h00;
        exp_fd = 1'b0;
    endtask

    // one bit per edge; every 8th bit since reset publishes a new word
    task automatic shift(input bit b, input string tag);
        d_in = b;
        @(posedge clock);
        #1;
        win.push_back(b);
        if (win.size() > 8) void'(win.pop_front());
        nbits++;
        exp_fd = 1'b0;
        if (nbits % 8 == 0) begin
            for (int i = 0; i < 8; i++) begin
                exp_m[7-i] = win[i];
                exp_l[i]   = win[i];
            end
            exp_fd = 1'b1;
        end
        chk_all(tag);
    endtask

    task automatic shift_byte(input logic [7:0] bits, input string tag);
        for (int i = 7; i >= 0; i--) shift(bits[i], tag);
    endtask

    // async reset asserted mid-cycle, held two edges, released at a falling edge
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all({tag, "_async"});
        repeat (2) begin
            @(posedge clock);
            #1;
            chk_all({tag, "_hold"});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int rst_at;
        #1;
        model_reset();
        chk_all("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        shift_byte(8'b1011_0010, "frame1");
        chk("frame1_const", d_out_m, 8'hB2);
        shift_byte(8'hFF, "frame2");
        chk("frame2_const", d_out_m, 8'hFF);

        do_reset("rst_nonzero");

        shift(1'b1, "partial");
        shift(1'b0, "partial");
        shift(1'b1, "partial");
        do_reset("rst_mid");
        shift_byte(8'b0000_1111, "after_rst");
        chk("after_rst_const", d_out_m, 8'h0F);

        shift_byte(8'b1000_0000, "lsb_first");
        chk("lsb_first_const", d_out_l, 8'h01);
        chk("lsb_first_msb_const", d_out_m, 8'h80);

        for (int i = 0; i < 40; i++) shift(1'b1, "const_one");

        rst_at = int'($urandom_range(20, 100));
        for (int i = 0; i < 200; i++) begin
            if (i == rst_at) do_reset("rst_rand");
            shift(1'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
